// File: rtl/ahb_arbiter_if.sv
// Arbitration signal bundle between the AHB masters/bus fabric and the arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int MW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic [2:0]             HBURST;
    logic                   HREADY;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [MW-1:0]          HMASTER;
    logic                   HMASTLOCK;

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        output HGRANT, HMASTER, HMASTLOCK
    );

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter. Grant is held inside fixed-length bursts and locked
// sequences, and moves while the last beat's address is on the bus so the next
// owner can start without a dead cycle.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic        clock,
    input  logic        HRESET,
    ahb_arbiter_if.slave bus
);
    localparam int MW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } trans_e;

    logic [MW-1:0]          g;
    logic [MW-1:0]          g_next;
    logic [MW-1:0]          sel;
    logic [MW-1:0]          master_q;
    logic                   mastlock_q;
    logic [4:0]             cnt;
    logic [4:0]             cnt_next;
    logic                   rearb;
    logic [NUM_MASTERS-1:0] grant;

    // Beats remaining after the first address phase of a burst (INCR counts as
    // a single beat so undefined-length bursts never hold the bus).
    function automatic logic [4:0] beats_after_first(input logic [2:0] burst);
        case (burst)
            3'd2, 3'd3: return 5'd3;
            3'd4, 3'd5: return 5'd7;
            3'd6, 3'd7: return 5'd15;
            default:    return 5'd0;
        endcase
    endfunction

    // Burst tracking: count down accepted beats; IDLE aborts, BUSY pauses.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        cnt_next = cnt;
        if (bus.HREADY) begin
            case (trans_e'(bus.HTRANS))
                TRANS_NONSEQ: cnt_next = beats_after_first(bus.HBURST);
                TRANS_SEQ:    if (cnt != 5'd0) cnt_next = cnt - 5'd1;
                TRANS_IDLE:   cnt_next = 5'd0;
                default:      cnt_next = cnt;
            endcase
        end
    end

    // Round-robin search starting after the current holder, ending with it.
    always_comb begin
        logic          found;
        int            idx;
        logic [MW-1:0] cand;
        sel   = MW'(DEFAULT_MASTER);
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx  = (int'(g) + i) % NUM_MASTERS;
            cand = MW'(idx);
            if (!found && bus.HBUSREQ[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Next grant: move only on a rearbitration edge (not locked, burst ending).
    always_comb begin
        rearb  = bus.HREADY && !bus.HLOCK[g] && (cnt_next <= 5'd1);
        g_next = rearb ? sel : g;
    end

    // State register: everything holds during wait states.
    always_ff @(posedge clock or negedge HRESET) begin
        if (!HRESET) begin
            g          <= MW'(DEFAULT_MASTER);
            master_q   <= MW'(DEFAULT_MASTER);
            mastlock_q <= 1'b0;
            cnt        <= 5'd0;
        end else begin
            // NOTE: non-blocking so master_q captures the old grant, not g_next.
            cnt <= cnt_next;
            if (bus.HREADY) begin
                g          <= g_next;
                master_q   <= g;
                mastlock_q <= bus.HLOCK[g];
            end
        end
    end

    // Output decode: one-hot grant and registered ownership.
    always_comb begin
        grant    = '0;
        grant[g] = 1'b1;
    end

    assign bus.HGRANT    = grant;
    assign bus.HMASTER   = master_q;
    assign bus.HMASTLOCK = mastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed scoreboard bench for ahb_arbiter: the driver pushes the expected
// post-edge outputs per cycle, a monitor pops and compares after each edge.
module tb_ahb_arbiter;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NS   = 2'd2;
    localparam logic [1:0] SEQ  = 2'd3;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] master;
        logic       lock;
        int         tag;
    } exp_t;

    logic clock;
    logic HRESET;
    int   checks = 0;
    int   errors = 0;
    int   tag    = 0;
    exp_t exp_q[$];
    exp_t async_q[$];
    event async_ev;

    ahb_arbiter_if #(.NUM_MASTERS(4)) bus ();

    ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .clock (clock),
        .HRESET(HRESET),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input exp_t e);
        checks++;
        if (bus.HGRANT !== e.grant || bus.HMASTER !== e.master || bus.HMASTLOCK !== e.lock) begin
            errors++;
            $display("FAIL step%0d got grant=%b master=%0d lock=%b expected grant=%b master=%0d lock=%b",
                     e.tag, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, e.grant, e.master, e.lock);
        end
    endtask

    // One bus cycle: drive inputs away from the edge, record expected post-edge outputs.
    task automatic step(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                        input logic [2:0] burst, input logic ready,
                        input logic [3:0] eg, input logic [1:0] em, input logic el);
        exp_t e;
        @(negedge clock);
        bus.HBUSREQ = req;
        bus.HLOCK   = lock;
        bus.HTRANS  = trans;
        bus.HBURST  = burst;
        bus.HREADY  = ready;
        e.grant = eg; e.master = em; e.lock = el; e.tag = tag;
        tag++;
        exp_q.push_back(e);
    endtask

    // Expectation for an asynchronous (edge-free) observation.
    task automatic expect_now(input logic [3:0] eg, input logic [1:0] em, input logic el);
        exp_t e;
        e.grant = eg; e.master = em; e.lock = el; e.tag = tag;
        tag++;
        async_q.push_back(e);
        -> async_ev;
    endtask

    task automatic idle_inputs();
        bus.HBUSREQ = 4'b0000;
        bus.HLOCK   = 4'b0000;
        bus.HTRANS  = IDLE;
        bus.HBURST  = 3'd0;
        bus.HREADY  = 1'b1;
    endtask

    // Monitor: compare after every rising edge when an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e);
            end
        end
    end

    // Monitor for asynchronous reset observations.
    initial begin
        exp_t e;
        forever begin
            @(async_ev);
            #1;
            if (async_q.size() > 0) begin
                e = async_q.pop_front();
                check(e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b0;
        idle_inputs();
        #1;
        expect_now(4'b0001, 2'd0, 1'b0);
        repeat (2) @(negedge clock);
        HRESET = 1'b1;

        // Round robin among 1,2,3 with SINGLE transfers.
        step(4'b1110, 4'b0000, NS, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0);
        step(4'b1110, 4'b0000, NS, 3'd0, 1'b1, 4'b0100, 2'd1, 1'b0);
        step(4'b1110, 4'b0000, NS, 3'd0, 1'b1, 4'b1000, 2'd2, 1'b0);
        step(4'b1110, 4'b0000, NS, 3'd0, 1'b1, 4'b0010, 2'd3, 1'b0);
        step(4'b1110, 4'b0000, NS, 3'd0, 1'b1, 4'b0100, 2'd1, 1'b0);

        // Hand the bus to master 1.
        step(4'b0010, 4'b0000, IDLE, 3'd0, 1'b1, 4'b0010, 2'd2, 1'b0);
        step(4'b0010, 4'b0000, IDLE, 3'd0, 1'b1, 4'b0010, 2'd1, 1'b0);

        // INCR4 by master 1 while master 2 requests.
        step(4'b0110, 4'b0000, NS,  3'd3, 1'b1, 4'b0010, 2'd1, 1'b0);
        step(4'b0110, 4'b0000, SEQ, 3'd3, 1'b1, 4'b0010, 2'd1, 1'b0);
        step(4'b0110, 4'b0000, SEQ, 3'd3, 1'b1, 4'b0100, 2'd1, 1'b0);
        step(4'b0100, 4'b0000, SEQ, 3'd3, 1'b1, 4'b0100, 2'd2, 1'b0);

        // Back to master 1, then INCR4 with two wait states on beat 2.
        step(4'b0010, 4'b0000, IDLE, 3'd0, 1'b1, 4'b0010, 2'd2, 1'b0);
        step(4'b0010, 4'b0000, IDLE, 3'd0, 1'b1, 4'b0010, 2'd1, 1'b0);
        step(4'b0110, 4'b0000, NS,  3'd3, 1'b1, 4'b0010, 2'd1, 1'b0);
        step(4'b0110, 4'b0000, SEQ, 3'd3, 1'b0, 4'b0010, 2'd1, 1'b0);
        step(4'b0110, 4'b0000, SEQ, 3'd3, 1'b0, 4'b0010, 2'd1, 1'b0);
        step(4'b0110, 4'b0000, SEQ, 3'd3, 1'b1, 4'b0010, 2'd1, 1'b0);
        step(4'b0110, 4'b0000, SEQ, 3'd3, 1'b1, 4'b0100, 2'd1, 1'b0);
        step(4'b0100, 4'b0000, SEQ, 3'd3, 1'b1, 4'b0100, 2'd2, 1'b0);

        // Master 2 locked for 3 SINGLEs; master 0 requests (its own HLOCK is ignored).
        step(4'b0101, 4'b0101, NS, 3'd0, 1'b1, 4'b0100, 2'd2, 1'b1);
        step(4'b0101, 4'b0101, NS, 3'd0, 1'b1, 4'b0100, 2'd2, 1'b1);
        step(4'b0101, 4'b0101, NS, 3'd0, 1'b1, 4'b0100, 2'd2, 1'b1);
        step(4'b0001, 4'b0001, IDLE, 3'd0, 1'b1, 4'b0001, 2'd2, 1'b0);
        step(4'b0001, 4'b0000, IDLE, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0);

        // Master 3 INCR16 aborted by IDLE after 5 beats while master 1 requests.
        step(4'b1000, 4'b0000, IDLE, 3'd0, 1'b1, 4'b1000, 2'd0, 1'b0);
        step(4'b1000, 4'b0000, IDLE, 3'd0, 1'b1, 4'b1000, 2'd3, 1'b0);
        step(4'b1010, 4'b0000, NS, 3'd7, 1'b1, 4'b1000, 2'd3, 1'b0);
        for (int i = 0; i < 4; i++)
            step(4'b1010, 4'b0000, SEQ, 3'd7, 1'b1, 4'b1000, 2'd3, 1'b0);
        step(4'b1010, 4'b0000, IDLE, 3'd7, 1'b1, 4'b0010, 2'd3, 1'b0);

        // Master 1 starts INCR8; reset lands mid-burst.
        step(4'b0010, 4'b0000, IDLE, 3'd0, 1'b1, 4'b0010, 2'd1, 1'b0);
        step(4'b0110, 4'b0000, NS,  3'd5, 1'b1, 4'b0010, 2'd1, 1'b0);
        step(4'b0110, 4'b0000, SEQ, 3'd5, 1'b1, 4'b0010, 2'd1, 1'b0);
        @(negedge clock);
        #1;
        HRESET = 1'b0;
        expect_now(4'b0001, 2'd0, 1'b0);
        @(negedge clock);
        expect_now(4'b0001, 2'd0, 1'b0);
        idle_inputs();
        #2;
        HRESET = 1'b1;

        // After reset: default master with no requests, then a fresh grant.
        step(4'b0000, 4'b0000, IDLE, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0);
        step(4'b0100, 4'b0000, IDLE, 3'd0, 1'b1, 4'b0100, 2'd0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        if (exp_q.size() > 0 || async_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size() + async_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin AHB bus arbiter that shares the single AHB address/data bus among `NUM_MASTERS` masters, each connected through its own master interface. It samples every master's `HBUSREQ`/`HLOCK` and drives a one-hot `HGRANT` back to each master. It tracks the owning master's burst so that grant never moves inside a fixed-length burst or a locked sequence. Its outputs `HMASTER` and `HMASTLOCK` steer the address/control multiplexer and inform slaves.

## Interface
- `NUM_MASTERS`, default 4: number of requesting masters; legal range 2..16.
- `DEFAULT_MASTER`, default 0: master granted when nobody requests; must be < `NUM_MASTERS`.
- `MW`, derived as `$clog2(NUM_MASTERS)`: width of the master index.
- `clock` input 1: bus clock; all state changes on the rising edge.
- `HRESET` input 1: reset, asynchronous, active-low.
- `HBUSREQ` input `NUM_MASTERS`: bit i is the bus request from master i.
- `HLOCK` input `NUM_MASTERS`: bit i is the locked-transfer request from master i.
- `HTRANS` input 2: transfer type of the current address phase (muxed bus). IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `HBURST` input 3: burst type of the current address phase (muxed bus).
- `HREADY` input 1: bus-wide transfer-complete.
- `HGRANT` output `NUM_MASTERS`: one-hot grant; always exactly one bit set.
- `HMASTER` output `MW`: index of the master owning the current address phase.
- `HMASTLOCK` output 1: the current address phase is part of a locked sequence.

## Operation
- The only state is the registered grant index `g` (drives `HGRANT`), `HMASTER`, `HMASTLOCK`, and the burst counter `cnt` (5 bits).
- `cnt` holds the beats still to be presented after the current address phase. Update happens only at edges with `HREADY`=1:
  - HTRANS=NONSEQ: `cnt` ← L-1, where L is 1 for SINGLE(0) and INCR(1), 4 for WRAP4/INCR4 (2,3), 8 for (4,5), 16 for (6,7).
  - HTRANS=SEQ with `cnt`>0: `cnt` ← `cnt`-1.
  - HTRANS=IDLE: `cnt` ← 0, which terminates the burst.
  - HTRANS=BUSY: `cnt` is held.
- Rearbitration edge: `HREADY`=1, `HLOCK[g]`=0, and `cnt_next` ≤ 1. This moves grant so it lands while the final beat's address is on the bus.
- INCR (undefined length) never blocks rearbitration.
- Selection at a rearbitration edge:
  - Search for a requester in order g+1, g+2, …, wrapping modulo `NUM_MASTERS`, ending with g itself; the first one with `HBUSREQ` set wins.
  - If no bit of `HBUSREQ` is set, `DEFAULT_MASTER` wins.
  - Selection is purely combinational from the current inputs. The current holder therefore has the lowest priority, which gives round-robin fairness.
- At any edge with `HREADY`=1: `HMASTER` ← g (the old grant) and `HMASTLOCK` ← `HLOCK[g]`.
- `HREADY`=0: `g`, `HMASTER`, `HMASTLOCK` and `cnt` all hold.
- While `HLOCK[g]`=1, grant is held even if other masters request and the burst has ended.

## Timing
- Reset (`HRESET`=0, asynchronous, applies mid-burst too):
  - `HGRANT` = one-hot(`DEFAULT_MASTER`), `HMASTER` = `DEFAULT_MASTER`, `HMASTLOCK`=0, `cnt`=0.
  - Release is synchronous to the next rising edge of `clock`.
- Request to grant: a request sampled at edge k changes `HGRANT` at edge k when k is a rearbitration edge. There are no extra pipeline stages.
- Grant to ownership: `HMASTER` follows `HGRANT` at the next edge with `HREADY`=1. The new master drives its first address in the cycle after that edge.
- A wait state (`HREADY`=0) on either edge stretches the corresponding step by the number of wait cycles.
- Simultaneous requests are resolved by the round-robin rule. Dropping a request and asserting a new one in the same cycle counts only the new one.
- A `HLOCK` bit from a master that does not hold the grant has no effect until that master is granted.

## Test plan
- Reset with `HBUSREQ`=0, `DEFAULT_MASTER`=0 → `HGRANT`=0001, `HMASTER`=0, `HMASTLOCK`=0. Assert `HRESET`=0 mid-INCR8 → outputs return to reset values without waiting for an edge.
- Masters 1, 2 and 3 request continuously, all transfers SINGLE, `HREADY`=1 → grant sequence 1→2→3→1… with one grant change per edge. `HMASTER` trails `HGRANT` by one cycle.
- Master 1 runs INCR4 while master 2 requests → `HGRANT` moves to 2 only at the edge that accepts beat 3. `HMASTER`=2 at the edge accepting beat 4.
- Same INCR4 with `HREADY`=0 for 2 cycles on beat 2 → grant switch delayed by exactly 2 cycles. `cnt` held during the wait.
- Master 2 holds `HLOCK`=1 for 3 SINGLE transfers while master 0 requests → `HGRANT` stays on 2 throughout and `HMASTLOCK`=1 for those 3 address phases. Master 0 is granted at the first edge after `HLOCK[2]` drops.
- Master 3 runs INCR16 and issues IDLE after 5 beats while master 1 requests → rearbitration at that IDLE edge and `HGRANT`=0010.
